// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one of N_REQ requesters write access to a shared register.
// Each write takes IDLE -> GRANT -> ACK; a requester that drops its request while granted aborts the write.
module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*W-1:0]       wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         ack,
  output logic [W-1:0]             q,
  output logic [$clog2(N_REQ)-1:0] q_src,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t         state, state_n;
  logic [IW-1:0]  ptr, ptr_n;
  logic [IW-1:0]  winner, winner_n;
  logic [IW-1:0]  q_src_n;
  logic [IW-1:0]  rr_win, idx;
  logic           rr_found;
  logic [N_REQ-1:0] gnt_n, ack_n;
  logic [W-1:0]   q_n;

  // Search starts at ptr and wraps, so the most recently served requester has lowest priority
  always_comb begin
    rr_found = 1'b0;
    rr_win   = ptr;
    idx      = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + IW'(k);
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_win   = idx;
      end
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    winner_n = winner;
    gnt_n    = '0;
    ack_n    = '0;
    q_n      = q;
    q_src_n  = q_src;
    case (state)
      IDLE: begin
        if (rr_found) begin
          winner_n = rr_win;
          gnt_n    = N_REQ'(1) << rr_win;
          state_n  = GRANT;
        end
      end
      GRANT: begin
        // The write only commits if the winner still holds its request
        if (req[winner]) begin
          q_n     = wdata[winner*W +: W];
          q_src_n = winner;
          ack_n   = N_REQ'(1) << winner;
          ptr_n   = winner + IW'(1);
          state_n = ACK;
        end else begin
          state_n = IDLE;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      winner <= '0;
      gnt    <= '0;
      ack    <= '0;
      q      <= '0;
      q_src  <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      winner <= winner_n;
      gnt    <= gnt_n;
      ack    <= ack_n;
      q      <= q_n;
      q_src  <= q_src_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter with hand-computed expectations.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] wdata;
  logic [3:0]  gnt, ack, q;
  logic [1:0]  q_src;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;

  reg_write_arbiter #(.N_REQ(4), .W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt), .ack(ack), .q(q), .q_src(q_src), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] d);
    req   = r;
    wdata = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] eGnt, input logic [3:0] eAck,
                          input logic [3:0] eQ, input logic [1:0] eSrc, input logic eBusy);
    checkOutput({tag, "_gnt"},   32'(gnt),   32'(eGnt));
    checkOutput({tag, "_ack"},   32'(ack),   32'(eAck));
    checkOutput({tag, "_q"},     32'(q),     32'(eQ));
    checkOutput({tag, "_q_src"}, 32'(q_src), 32'(eSrc));
    checkOutput({tag, "_busy"},  32'(busy),  32'(eBusy));
  endtask

  initial begin
    // Reset held two cycles with every requester asking
    rst = 1'b1;
    applyStimulus(4'b1111, 16'hFFFF);
    step(); checkAll("rst1", 4'b0000, 4'b0000, 4'h0, 2'd0, 1'b0);
    step(); checkAll("rst2", 4'b0000, 4'b0000, 4'h0, 2'd0, 1'b0);
    rst = 1'b0;
    applyStimulus(4'b0000, 16'h0000);
    step(); checkAll("idle", 4'b0000, 4'b0000, 4'h0, 2'd0, 1'b0);

    // Single write from requester 2; other slices must not reach q
    applyStimulus(4'b0100, 16'h5A3C);
    step(); checkAll("single_g", 4'b0100, 4'b0000, 4'h0, 2'd0, 1'b1);
    step(); checkAll("single_a", 4'b0000, 4'b0100, 4'hA, 2'd2, 1'b1);
    applyStimulus(4'b0000, 16'h0000);
    step(); checkAll("single_i", 4'b0000, 4'b0000, 4'hA, 2'd2, 1'b0);

    // Reset restores ptr to 0 before the rotation test
    rst = 1'b1;
    step(); checkAll("rst3", 4'b0000, 4'b0000, 4'h0, 2'd0, 1'b0);
    rst = 1'b0;

    // All four requesting continuously: grants rotate 0,1,2,3,0
    applyStimulus(4'b1111, 16'h4321);
    for (int i = 0; i < 5; i++) begin
      step(); checkAll($sformatf("rr%0d_g", i), 4'(1 << (i % 4)), 4'b0000,
                       (i == 0) ? 4'h0 : 4'(((i - 1) % 4) + 1), (i == 0) ? 2'd0 : 2'((i - 1) % 4), 1'b1);
      step(); checkAll($sformatf("rr%0d_a", i), 4'b0000, 4'(1 << (i % 4)),
                       4'((i % 4) + 1), 2'(i % 4), 1'b1);
      if (i == 4) applyStimulus(4'b0000, 16'h4321);
      step(); checkAll($sformatf("rr%0d_i", i), 4'b0000, 4'b0000,
                       4'((i % 4) + 1), 2'(i % 4), 1'b0);
    end

    // Winner 3 wraps ptr to 0
    applyStimulus(4'b1000, 16'hC000);
    step(); checkAll("w3_g", 4'b1000, 4'b0000, 4'h1, 2'd0, 1'b1);
    step(); checkAll("w3_a", 4'b0000, 4'b1000, 4'hC, 2'd3, 1'b1);
    applyStimulus(4'b0000, 16'h0000);
    step(); checkAll("w3_i", 4'b0000, 4'b0000, 4'hC, 2'd3, 1'b0);

    // Abort: requester 0 drops while granted
    applyStimulus(4'b0001, 16'h0065);
    step(); checkAll("abort_g", 4'b0001, 4'b0000, 4'hC, 2'd3, 1'b1);
    applyStimulus(4'b0000, 16'h0065);
    step(); checkAll("abort_x", 4'b0000, 4'b0000, 4'hC, 2'd3, 1'b0);
    applyStimulus(4'b0011, 16'h0065);
    step(); checkAll("abort_ptr_g", 4'b0001, 4'b0000, 4'hC, 2'd3, 1'b1);
    step(); checkAll("abort_ptr_a", 4'b0000, 4'b0001, 4'h5, 2'd0, 1'b1);
    applyStimulus(4'b0000, 16'h0065);
    step(); checkAll("abort_ptr_i", 4'b0000, 4'b0000, 4'h5, 2'd0, 1'b0);

    // Reset in the middle of a grant discards the write
    applyStimulus(4'b0100, 16'h0B00);
    step(); checkAll("midrst_g", 4'b0100, 4'b0000, 4'h5, 2'd0, 1'b1);
    rst = 1'b1;
    step(); checkAll("midrst_r", 4'b0000, 4'b0000, 4'h0, 2'd0, 1'b0);
    rst = 1'b0;
    applyStimulus(4'b1000, 16'h7B00);
    step(); checkAll("midrst_g3", 4'b1000, 4'b0000, 4'h0, 2'd0, 1'b1);
    step(); checkAll("midrst_a3", 4'b0000, 4'b1000, 4'h7, 2'd3, 1'b1);
    applyStimulus(4'b0000, 16'h0000);
    step(); checkAll("midrst_i", 4'b0000, 4'b0000, 4'h7, 2'd3, 1'b0);

    // Grant to 2 leaves ptr=3; then req 1001 serves 3 before 0
    applyStimulus(4'b0100, 16'h0200);
    step(); checkAll("wrap_g2", 4'b0100, 4'b0000, 4'h7, 2'd3, 1'b1);
    step(); checkAll("wrap_a2", 4'b0000, 4'b0100, 4'h2, 2'd2, 1'b1);
    applyStimulus(4'b1001, 16'h9001);
    step(); checkAll("wrap_i2", 4'b0000, 4'b0000, 4'h2, 2'd2, 1'b0);
    step(); checkAll("wrap_g3", 4'b1000, 4'b0000, 4'h2, 2'd2, 1'b1);
    step(); checkAll("wrap_a3", 4'b0000, 4'b1000, 4'h9, 2'd3, 1'b1);
    step(); checkAll("wrap_i3", 4'b0000, 4'b0000, 4'h9, 2'd3, 1'b0);
    step(); checkAll("wrap_g0", 4'b0001, 4'b0000, 4'h9, 2'd3, 1'b1);
    step(); checkAll("wrap_a0", 4'b0000, 4'b0001, 4'h1, 2'd0, 1'b1);
    applyStimulus(4'b0000, 16'h0000);
    step(); checkAll("wrap_i0", 4'b0000, 4'b0000, 4'h1, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (fixed at 4 for this revision).
REQ-002 SHALL have parameter W, default 4, data width of the shared register.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  4  per-requester write request, bit i = requester i.
REQ-006 SHALL have port wdata  input  16  packed write data, requester i at bits [4i+3:4i].
REQ-007 SHALL have port gnt  output  4  one-hot grant, registered.
REQ-008 SHALL have port ack  output  4  one-hot write-done pulse, registered.
REQ-009 SHALL have port q  output  4  shared register contents.
REQ-010 SHALL have port q_src  output  2  index of requester that last wrote q.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM with states IDLE, GRANT and ACK; no other states reachable.
REQ-013 In IDLE with req==0, SHALL remain in IDLE with gnt=0, ack=0, q unchanged.
REQ-014 In IDLE with req!=0, SHALL select winner by round-robin: lowest index i with req[i]=1, searching ptr, ptr+1, ... mod 4.
REQ-015 On that edge SHALL set gnt=onehot(winner), latch winner index, go to GRANT.
REQ-016 In GRANT, if req[winner] still 1, SHALL at next edge load q<=wdata slice of winner, q_src<=winner, ack=onehot(winner), gnt=0, ptr<=(winner+1) mod 4, go to ACK.
REQ-017 In GRANT, if req[winner] has dropped (abort), SHALL leave q, q_src, ptr unchanged, ack=0, gnt=0, go to IDLE.
REQ-018 In ACK, SHALL ignore req, clear ack to 0 at next edge, go to IDLE.
REQ-019 ack SHALL be a single-cycle pulse; gnt and ack SHALL never be nonzero in the same cycle.
REQ-020 Latency: req sampled high in IDLE -> gnt next cycle -> q and ack updated one cycle later; max one write per 3 cycles.
REQ-021 Requests from losers SHALL be held pending (no loss); arbiter does not store them, requester keeps req high.
REQ-022 wdata of non-granted requesters SHALL never affect q.
REQ-023 Round-robin SHALL be starvation-free: with all 4 requesting continuously, grants rotate 0,1,2,3,0...
REQ-024 ptr SHALL wrap from 3 to 0; winner 3 sets ptr=0.
REQ-025 Changes of req during ACK SHALL have no effect until next IDLE cycle.

Reset
REQ-026 When rst=1 at a rising edge, SHALL set state=IDLE, ptr=0, gnt=0, ack=0, q=0, q_src=0, busy=0.
REQ-027 rst SHALL take priority over all FSM transitions, including mid-GRANT or mid-ACK; an in-flight write SHALL be discarded.
REQ-028 Outputs SHALL not change asynchronously with rst; effect only at rising clk edge.

Verification
REQ-029 Reset: rst=1 two cycles, req=4'b1111 -> q=0, q_src=0, gnt=0, ack=0, busy=0 throughout.
REQ-030 Single write: req=4'b0100, wdata[11:8]=4'b1010 -> gnt=0100 at cycle+1, q=1010, q_src=2, ack=0100 at cycle+2, busy low at cycle+3.
REQ-031 Round-robin: req=4'b1111 held, wdata slices 1,2,3,4 -> q sequence 1,2,3,4,1 every 3 cycles, ack order 0001,0010,0100,1000,0001.
REQ-032 Abort: req=4'b0001, drop req[0] while gnt=0001 -> no ack, q unchanged, ptr unchanged (next req=4'b0011 grants 0).
REQ-033 Reset mid-operation: rst=1 while state=GRANT with wdata=4'b1011 -> q stays 0, gnt=0 next cycle, subsequent req=4'b1000 grants requester 3.
REQ-034 Wrap: ptr=3 after grant to 2, req=4'b1001 -> grant 3 then 0.
